// File: rtl/io_bus_sense.sv
// Receive side of the shared 3-line priority I/O bus: synchronise, debounce, decode owner,
// and queue every settled line change as a timestamped event for the host.
module io_bus_sense #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int DEPTH       = 4,
  parameter int TS_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      bus_in,
  output logic [2:0]      lines,
  output logic [1:0]      owner,
  output logic            owner_valid,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [2:0]      ev_lines,
  output logic [1:0]      ev_owner,
  output logic [TS_W-1:0] ev_time,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EV_W  = 3 + 2 + TS_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Lowest set index owns the bus; an idle bus reports owner 0.
  function automatic logic [1:0] owner_of(input logic [2:0] l);
    logic [1:0] o;
    o = 2'd0;
    if (l[0])      o = 2'd0;
    else if (l[1]) o = 2'd1;
    else if (l[2]) o = 2'd2;
    return o;
  endfunction

  // ---------------- synchroniser ----------------
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
    end else begin
      sync_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------- debounce ----------------
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             update;

  assign update = (s == cand) && (cand != lines) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= 3'b000;
      cnt   <= '0;
      lines <= 3'b000;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cand != lines) begin
      if (cnt == CNT_LAST) begin
        lines <= cand;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign owner       = owner_of(lines);
  assign owner_valid = |lines;

  // ---------------- timestamp ----------------
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // ---------------- event FIFO ----------------
  // Handshake: ev_valid means the head entry is presented on ev_*; the entry is
  // consumed on a rising edge where ev_valid && ev_ready, and ev_* stay stable
  // while ev_valid is high and ev_ready is low.
  logic [EV_W-1:0] mem [DEPTH];
  logic [PTR_W:0]  wr_ptr;
  logic [PTR_W:0]  rd_ptr;
  logic [PTR_W:0]  count;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;
  logic [EV_W-1:0] head;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && ev_ready;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push  = update && (!full || pop);
  assign drop  = update && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {cand, owner_of(cand), ts};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  assign head     = mem[rd_ptr[PTR_W-1:0]];
  assign ev_valid = !empty;
  assign ev_lines = ev_valid ? head[EV_W-1 -: 3]    : 3'b000;
  assign ev_owner = ev_valid ? head[TS_W+1 -: 2]    : 2'b00;
  assign ev_time  = ev_valid ? head[TS_W-1:0]       : '0;

endmodule

// File: tb/tb_io_bus_sense.sv
// Self-checking bench for io_bus_sense: vector table for settled changes plus
// hand-written sequences for glitches, FIFO full/overflow and mid-debounce reset.
module tb_io_bus_sense;

  localparam int TS_W = 16;
  localparam int EV_W = 3 + 2 + TS_W;

  logic            clk;
  logic            rst_n;
  logic [2:0]      bus_in;
  logic [2:0]      lines;
  logic [1:0]      owner;
  logic            owner_valid;
  logic            ev_valid;
  logic            ev_ready;
  logic [2:0]      ev_lines;
  logic [1:0]      ev_owner;
  logic [TS_W-1:0] ev_time;
  logic            overflow;
  logic            clr_overflow;

  io_bus_sense #(
    .SYNC_STAGES(2), .DEBOUNCE(4), .DEPTH(4), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
    .lines(lines), .owner(owner), .owner_valid(owner_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_lines(ev_lines), .ev_owner(ev_owner), .ev_time(ev_time),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time base: edges counted since reset release.
  logic [TS_W-1:0] tb_ts;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [EV_W-1:0] exp_q[$];
  logic [2:0]      cur_lines;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ev_pop: got event lines=%b time=%0d, expected no event", ev_lines, ev_time);
      end else begin
        logic [EV_W-1:0] e;
        e = exp_q.pop_front();
        n_pops++;
        check("ev_pop", {ev_lines, ev_owner, ev_time}, e);
      end
    end
  end

  function automatic logic [1:0] model_owner(input logic [2:0] l);
    casez (l)
      3'b??1:  return 2'd0;
      3'b?10:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a steady value and check the latency window; queue the event if accepted.
  task automatic apply(input logic [2:0] val, input logic [1:0] exp_owner,
                       input logic exp_ov, input bit queued);
    logic [2:0]      prev;
    logic [TS_W-1:0] t;
    prev   = cur_lines;
    t      = tb_ts;
    bus_in = val;
    if (val != prev && queued) exp_q.push_back({val, exp_owner, TS_W'(t + 6)});
    tick(6);
    check("lines_hold", lines, prev);
    tick(1);
    check("lines", lines, val);
    check("owner", owner, exp_owner);
    check("owner_valid", owner_valid, exp_ov);
    cur_lines = val;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    ev_ready = 1'b1;
    while (ev_valid && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_done", ev_valid, 1'b0);
  endtask

  typedef struct {
    logic [2:0] bus;
    logic [2:0] lines;
    logic [1:0] owner;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [TS_W-1:0] t0;
    logic [2:0]      v;
    int              pops0;

    vecs[0] = '{3'b110, 3'b110, 2'd1, 1'b1};
    vecs[1] = '{3'b111, 3'b111, 2'd0, 1'b1};
    vecs[2] = '{3'b101, 3'b101, 2'd0, 1'b1};
    vecs[3] = '{3'b010, 3'b010, 2'd1, 1'b1};
    vecs[4] = '{3'b000, 3'b000, 2'd0, 1'b0};
    vecs[5] = '{3'b011, 3'b011, 2'd0, 1'b1};
    vecs[6] = '{3'b100, 3'b100, 2'd2, 1'b1};

    rst_n = 1'b0; bus_in = 3'b000; ev_ready = 1'b0; clr_overflow = 1'b0;
    cur_lines = 3'b000;
    #23;
    check("rst_lines", lines, 3'b000);
    check("rst_owner_valid", owner_valid, 1'b0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    tick(1);
    rst_n = 1'b1;

    // First settled change after release.
    ev_ready = 1'b1;
    t0 = tb_ts;
    apply(3'b100, 2'd2, 1'b1, 1'b1);
    check("t1_ev_valid", ev_valid, 1'b1);
    check("t1_ev_lines", ev_lines, 3'b100);
    check("t1_ev_time", ev_time, TS_W'(t0 + 6));
    tick(2);

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].bus, vecs[i].owner, vecs[i].ov, 1'b1);
      tick(2);
    end

    for (int i = 0; i < 6; i++) begin
      v = 3'($urandom_range(0, 7));
      apply(v, model_owner(v), |v, 1'b1);
      tick(1);
    end
    drain(10);
    check("table_q_empty", exp_q.size(), 0);

    // Short pulses (3 and 4 cycles) must be filtered out.
    apply(3'b000, 2'd0, 1'b0, 1'b1);
    drain(10);
    bus_in = 3'b001; tick(3); bus_in = 3'b000; tick(12);
    check("glitch3_lines", lines, 3'b000);
    check("glitch3_ev_valid", ev_valid, 1'b0);
    bus_in = 3'b001; tick(4); bus_in = 3'b000; tick(12);
    check("glitch4_lines", lines, 3'b000);
    check("glitch4_ev_valid", ev_valid, 1'b0);

    // Five changes with no consumer: four held, fifth dropped.
    ev_ready = 1'b0;
    apply(3'b001, 2'd0, 1'b1, 1'b1);
    apply(3'b011, 2'd0, 1'b1, 1'b1);
    apply(3'b111, 2'd0, 1'b1, 1'b1);
    apply(3'b110, 2'd1, 1'b1, 1'b1);
    apply(3'b100, 2'd2, 1'b1, 1'b0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", ev_lines, 3'b001);
    tick(3);
    check("ovf_head_stable", ev_lines, 3'b001);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    // Drop coinciding with clear: set wins, clear applies on the next edge.
    clr_overflow = 1'b1;
    apply(3'b010, 2'd1, 1'b1, 1'b0);
    check("ovf_set_wins", overflow, 1'b1);
    tick(1);
    check("ovf_clr_after", overflow, 1'b0);
    clr_overflow = 1'b0;
    drain(20);
    check("ovf_q_empty", exp_q.size(), 0);

    // Full FIFO, update edge coincides with a pop.
    ev_ready = 1'b0;
    apply(3'b011, 2'd0, 1'b1, 1'b1);
    apply(3'b001, 2'd0, 1'b1, 1'b1);
    apply(3'b101, 2'd0, 1'b1, 1'b1);
    apply(3'b100, 2'd2, 1'b1, 1'b1);
    pops0 = n_pops;
    t0 = tb_ts;
    bus_in = 3'b110;
    exp_q.push_back({3'b110, 2'd1, TS_W'(t0 + 6)});
    tick(6);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    cur_lines = 3'b110;
    check("coinc_lines", lines, 3'b110);
    check("coinc_overflow", overflow, 1'b0);
    check("coinc_head", ev_lines, 3'b001);
    drain(20);
    check("coinc_pop_count", n_pops - pops0, 5);
    check("coinc_q_empty", exp_q.size(), 0);

    // Reset in the middle of a debounce with events queued.
    ev_ready = 1'b0;
    apply(3'b111, 2'd0, 1'b1, 1'b1);
    apply(3'b011, 2'd0, 1'b1, 1'b1);
    bus_in = 3'b101;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_lines", lines, 3'b000);
    check("mid_rst_owner", owner, 2'd0);
    check("mid_rst_owner_valid", owner_valid, 1'b0);
    check("mid_rst_ev_valid", ev_valid, 1'b0);
    check("mid_rst_ev_fields", {ev_lines, ev_owner, ev_time}, '0);
    check("mid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    cur_lines = 3'b000;
    bus_in = 3'b010;
    tick(2);
    rst_n = 1'b1;
    pops0 = n_pops;
    apply(3'b010, 2'd1, 1'b1, 1'b1);
    check("post_rst_ev_valid", ev_valid, 1'b1);
    check("post_rst_ev_time", ev_time, 16'd6);
    drain(10);
    tick(10);
    check("post_rst_pop_count", n_pops - pops0, 1);
    check("post_rst_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
